// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: synchronizes and debounces sw_raw, emits edge pulses,
// and generates a selectable-rate step tick while the debounced switch is on.
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_DIV        = 50_000_000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       sw_raw,
    input  logic [1:0] speed_sel,
    output logic       switch,
    output logic       sw_rise,
    output logic       sw_fall,
    output logic       step_tick
);

    // state     | meaning
    // STABLE_LO | debounced level 0, input agrees
    // WAIT_HI   | input high, counting toward a confirmed rise
    // STABLE_HI | debounced level 1, input agrees
    // WAIT_LO   | input low, counting toward a confirmed fall
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STEP_W = $clog2(BASE_DIV);

    localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    logic sync1;
    logic sync2;

    db_state_t       state;
    db_state_t       state_nx;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nx;
    logic            switch_nx;

    logic [1:0]        speed_q;
    logic [1:0]        speed_prev;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] period_last;
    logic              step_clear;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state   <= STABLE_LO;
            db_cnt  <= '0;
            switch  <= 1'b0;
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            state   <= state_nx;
            db_cnt  <= db_cnt_nx;
            switch  <= switch_nx;
            sw_rise <= switch_nx & ~switch;
            sw_fall <= ~switch_nx & switch;
        end
    end

    // The count reaching DEBOUNCE_CYCLES and the switch update share one edge,
    // so the terminal compare is against DEBOUNCE_CYCLES-1 before incrementing.
    always_comb begin
        state_nx  = state;
        db_cnt_nx = db_cnt;
        switch_nx = switch;
        case (state)
            STABLE_LO: begin
                if (sync2) begin
                    state_nx  = WAIT_HI;
                    db_cnt_nx = DB_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync2) begin
                    state_nx  = STABLE_LO;
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx  = STABLE_HI;
                    db_cnt_nx = '0;
                    switch_nx = 1'b1;
                end else begin
                    db_cnt_nx = db_cnt + DB_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    state_nx  = WAIT_LO;
                    db_cnt_nx = DB_ONE;
                end
            end
            WAIT_LO: begin
                if (sync2) begin
                    state_nx  = STABLE_HI;
                    db_cnt_nx = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nx  = STABLE_LO;
                    db_cnt_nx = '0;
                    switch_nx = 1'b0;
                end else begin
                    db_cnt_nx = db_cnt + DB_ONE;
                end
            end
            default: begin
                state_nx  = STABLE_LO;
                db_cnt_nx = '0;
                switch_nx = 1'b0;
            end
        endcase
    end

    always_comb begin
        period_last = STEP_W'(BASE_DIV - 1);
        case (speed_q)
            2'd0: period_last = STEP_W'(BASE_DIV - 1);
            2'd1: period_last = STEP_W'((BASE_DIV >> 1) - 1);
            2'd2: period_last = STEP_W'((BASE_DIV >> 2) - 1);
            2'd3: period_last = STEP_W'((BASE_DIV >> 3) - 1);
            default: period_last = STEP_W'(BASE_DIV - 1);
        endcase
    end

    assign step_clear = ~switch | sw_rise | (speed_q != speed_prev);

    // >= guards against a count left above a shorter period by a rate change.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            speed_q    <= 2'd0;
            speed_prev <= 2'd0;
            step_cnt   <= '0;
        end else begin
            speed_q    <= speed_sel;
            speed_prev <= speed_q;
            if (step_clear) begin
                step_cnt <= '0;
            end else if (step_cnt >= period_last) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + STEP_ONE;
            end
        end
    end

    assign step_tick = switch & ~sw_fall & (step_cnt == period_last);

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner: directed scenarios plus randomized
// switch activity, compared every cycle against a behavioural reference.
module tb_switch_conditioner;

    localparam int D    = 4;
    localparam int BASE = 16;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic       sw_raw;
    logic [1:0] speed_sel;
    logic       switch;
    logic       sw_rise;
    logic       sw_fall;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    // reference state: sync pipeline, run length of disagreeing samples, outputs
    bit m_s1, m_s2, m_sw, m_rise, m_fall, m_tick;
    int m_run, m_cnt, m_spd_q, m_spd_prev;

    always #10 clk_50M = ~clk_50M;

    switch_conditioner #(.DEBOUNCE_CYCLES(D), .BASE_DIV(BASE)) dut (
        .clk_50M   (clk_50M),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .speed_sel (speed_sel),
        .switch    (switch),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .step_tick (step_tick)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Switch flips once D consecutive synchronized samples disagree with it;
    // step ticks fire on the last count of a period P = BASE >> speed.
    task automatic model_edge(input bit raw, input int spd, input bit rst);
        bit nsw, clr;
        int nrun, ncnt, per;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_sw = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_cnt = 0; m_spd_q = 0; m_spd_prev = 0;
        end else begin
            per  = BASE >> m_spd_q;
            clr  = !m_sw || m_rise || (m_spd_q != m_spd_prev);
            ncnt = clr ? 0 : ((m_cnt + 1) % per);
            nsw  = m_sw;
            nrun = 0;
            if (m_s2 != m_sw) begin
                nrun = m_run + 1;
                if (nrun == D) begin
                    nsw  = !m_sw;
                    nrun = 0;
                end
            end
            m_rise     = nsw && !m_sw;
            m_fall     = !nsw && m_sw;
            m_sw       = nsw;
            m_run      = nrun;
            m_cnt      = ncnt;
            m_s2       = m_s1;
            m_s1       = raw;
            m_spd_prev = m_spd_q;
            m_spd_q    = spd;
        end
        m_tick = m_sw && !m_fall && (m_cnt == (BASE >> m_spd_q) - 1);
    endtask

    task automatic cyc(input bit raw, input int spd, input bit rst);
        sw_raw    = raw;
        speed_sel = 2'(spd);
        rst_n     = rst;
        @(posedge clk_50M);
        model_edge(raw, spd, rst);
        #1;
        chk("switch", switch, m_sw);
        chk("sw_rise", sw_rise, m_rise);
        chk("sw_fall", sw_fall, m_fall);
        chk("step_tick", step_tick, m_tick);
        chk("rise_fall_exclusive", sw_rise & sw_fall, 1'b0);
    endtask

    initial begin
        int n;
        int spd;
        int raw;
        int hold;
        sw_raw    = 1'b0;
        speed_sel = 2'd0;
        rst_n     = 1'b0;

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("reset_switch", switch, 1'b0);
        chk("reset_tick", step_tick, 1'b0);

        // clean rise: switch on edge 6, first tick 16 later, then period 16
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!switch && n < 20);
        chk_int("rise_latency", n, 6);
        chk("rise_pulse", sw_rise, 1'b1);
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!step_tick && n < 40);
        chk_int("first_tick", n, 16);
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!step_tick && n < 40);
        chk_int("tick_period_16", n, 16);

        // rate change mid-period: /4 then /8
        repeat (5) cyc(1, 0, 1);
        cyc(1, 2, 1);
        n = 0;
        do begin cyc(1, 2, 1); n++; end while (!step_tick && n < 40);
        n = 0;
        do begin cyc(1, 2, 1); n++; end while (!step_tick && n < 40);
        chk_int("tick_period_4", n, 4);
        cyc(1, 3, 1);
        n = 0;
        do begin cyc(1, 3, 1); n++; end while (!step_tick && n < 40);
        n = 0;
        do begin cyc(1, 3, 1); n++; end while (!step_tick && n < 40);
        chk_int("tick_period_2", n, 2);

        // fall landing on the final count of a period
        cyc(1, 0, 1);
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!step_tick && n < 40);
        repeat (10) cyc(1, 0, 1);
        n = 0;
        do begin cyc(0, 0, 1); n++; end while (switch && n < 20);
        chk_int("fall_latency", n, 6);
        chk("fall_pulse", sw_fall, 1'b1);
        chk("fall_tick_suppressed", step_tick, 1'b0);
        repeat (20) cyc(0, 0, 1);

        // bounce from low: 3 high, 2 low, then held high
        repeat (3) cyc(1, 0, 1);
        repeat (2) cyc(0, 0, 1);
        chk("bounce_no_switch", switch, 1'b0);
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!switch && n < 20);
        chk_int("bounce_latency", n, 6);

        // reset while heading low with a tick pending
        repeat (12) cyc(1, 0, 1);
        repeat (4) cyc(0, 0, 1);
        cyc(1, 0, 0);
        chk("midreset_switch", switch, 1'b0);
        chk("midreset_rise", sw_rise, 1'b0);
        chk("midreset_fall", sw_fall, 1'b0);
        chk("midreset_tick", step_tick, 1'b0);
        n = 0;
        do begin cyc(1, 0, 1); n++; end while (!switch && n < 20);
        chk_int("midreset_latency", n, 6);
        chk("midreset_rise_pulse", sw_rise, 1'b1);

        // randomized bounce/hold runs with occasional rate changes and resets
        spd = 0;
        raw = 1;
        for (int i = 0; i < 400; i++) begin
            raw  = raw ^ 1;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 40) : $urandom_range(1, 5);
            if ($urandom_range(0, 5) == 0) spd = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                cyc(raw[0], spd, ($urandom_range(0, 299) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, number of consecutive stable cycles needed before the output level changes (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter BASE_DIV, default 50_000_000, step period in clocks at speed_sel = 0; legal values are >= 8 and divisible by 8.
REQ-003 Port clk_50M, input, 1 bit, the single 50 MHz clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 Port sw_raw, input, 1 bit, raw, bouncing, asynchronous slide switch.
REQ-006 Port speed_sel, input, 2 bits, step-rate select; treated as quasi-static.
REQ-007 Port switch, output, 1 bit, registered debounced level; drives the LED effect enable.
REQ-008 Port sw_rise, output, 1 bit, one-clock pulse on a debounced 0->1 transition.
REQ-009 Port sw_fall, output, 1 bit, one-clock pulse on a debounced 1->0 transition.
REQ-010 Port step_tick, output, 1 bit, one-clock pulse at the selected step rate; active only while switch = 1.

Function
REQ-011 sw_raw SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 The debouncer FSM SHALL have four states: STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-013 In STABLE_x, when sync2 differs from the state level, the FSM SHALL enter WAIT_y with the count set to 1.
REQ-014 In WAIT_y, when sync2 equals the target level, the count SHALL increment; when the count reaches DEBOUNCE_CYCLES, the FSM SHALL enter STABLE_y and update switch on the same edge.
REQ-015 In WAIT_y, any cycle with sync2 back at the old level SHALL return the FSM to STABLE_x with the count cleared; switch does not change.
REQ-016 Latency: for a clean step on sw_raw, switch SHALL change on the (DEBOUNCE_CYCLES+2)th rising edge after the change.
REQ-017 sw_rise and sw_fall SHALL be registered and high for exactly the first cycle in which switch shows its new value; they are never high together.
REQ-018 Step period P SHALL equal BASE_DIV >> speed_sel, i.e. BASE_DIV, /2, /4 or /8.
REQ-019 speed_sel SHALL be registered each cycle; a change in the registered value SHALL clear the step counter to 0 on the next edge.
REQ-020 While switch = 0, the step counter SHALL hold at 0 and step_tick SHALL be 0.
REQ-021 While switch = 1, the step counter SHALL count 0..P-1 and wrap to 0, with step_tick = 1 during the cycle in which the counter equals P-1.
REQ-022 The step counter SHALL be cleared in the cycle sw_rise is high; the first step_tick SHALL appear P cycles after sw_rise.
REQ-023 On sw_fall, step_tick SHALL be forced to 0 in that same cycle even if the counter equals P-1.
REQ-024 Counter widths SHALL be sized from the parameters ($clog2); no counter may wrap unintentionally at the default values.

Reset
REQ-025 With rst_n = 0 on a clock edge, the block SHALL set: sync1 = sync2 = 0; FSM in STABLE_LO; all counters 0; switch, sw_rise, sw_fall and step_tick all 0.
REQ-026 Reset SHALL override all other activity, including mid-WAIT and mid-step-period.
REQ-027 After release, a high sw_raw SHALL produce switch = 1 through the normal debounce path with latency per REQ-016, and sw_rise SHALL pulse.

Verification (DEBOUNCE_CYCLES = 4, BASE_DIV = 16)
REQ-028 Clean rise: reset, then sw_raw 0->1 and held -> switch = 1 on edge 6; sw_rise high for one cycle; first step_tick 16 cycles later, then every 16 cycles.
REQ-029 Bounce: sw_raw 1 for 3 cycles, 0 for 2, then 1 held -> switch stays 0 through the glitch; no sw_rise until 4 stable cycles after sync, i.e. edge 6 after the final rise.
REQ-030 Rate change: switch = 1, speed_sel 0->2 mid-period -> counter clears; step_tick every 4 cycles thereafter; speed_sel = 3 -> every 2 cycles.
REQ-031 Fall: switch = 1, sw_raw 1->0 held -> switch = 0 on edge 6; sw_fall for one cycle; no step_tick from that cycle on, even when the fall coincides with counter = 15.
REQ-032 Reset mid-operation: rst_n low for 1 cycle while in WAIT_LO with a tick pending -> all outputs 0 next cycle; with sw_raw = 1 held, switch returns to 1 after 6 edges.
